// File: rtl/tx_huge_pages_ctrl.sv
// TX huge-page control: snoops host memory writes to one BAR on the TRN RX stream and
// holds per-page DMA address / qword count / ownership, completion buffer address and IRQ enable.
module tx_huge_pages_ctrl #(
  parameter int NUM_PAGES = 4,
  parameter int BAR_INDEX = 2
) (
  input  logic                     trn_clk,
  input  logic                     reset,
  input  logic [63:0]              trn_rd,
  input  logic [7:0]               trn_rrem_n,
  input  logic                     trn_rsof_n,
  input  logic                     trn_reof_n,
  input  logic                     trn_rsrc_rdy_n,
  input  logic                     trn_rsrc_dsc_n,
  input  logic [6:0]               trn_rbar_hit_n,
  input  logic                     trn_rdst_rdy_n,
  output logic [NUM_PAGES*64-1:0]  huge_page_addr,
  output logic [NUM_PAGES*32-1:0]  huge_page_qwords,
  output logic [NUM_PAGES-1:0]     huge_page_status,
  output logic [NUM_PAGES-1:0]     huge_page_unlock,
  input  logic [NUM_PAGES-1:0]     huge_page_free,
  output logic [63:0]              completed_buffer_address,
  output logic                     interrupts_enabled,
  output logic [15:0]              dropped_tlp_count
);

  localparam logic [6:0] FT_WR32 = 7'b10_00000;
  localparam logic [6:0] FT_WR64 = 7'b11_00000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A3   = 3'd1,
    S_A4   = 3'd2,
    S_D    = 3'd3,
    S_DROP = 3'd4
  } state_t;

  // Payload DWs arrive byte-reversed relative to the register image.
  function automatic logic [31:0] f_bswap(input logic [31:0] d);
    f_bswap = {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  state_t                  r_state;
  state_t                  w_state_nxt;
  state_t                  w_dec_state;

  logic                    r_is64;
  logic                    r_len2;
  logic [5:0]              r_off;
  logic [31:0]             r_data0;
  logic [NUM_PAGES*64-1:0] r_addr;
  logic [NUM_PAGES*32-1:0] r_qwords;
  logic [NUM_PAGES-1:0]    r_status;
  logic [NUM_PAGES-1:0]    r_unlock;
  logic [63:0]             r_cbuf;
  logic                    r_intr;
  logic [15:0]             r_drop;

  logic                    w_beat;
  logic                    w_sof;
  logic                    w_eof;
  logic                    w_dsc;
  logic                    w_hit;
  logic                    w_ft_wr;
  logic                    w_len_ok;
  logic                    w_dec_load;
  logic                    w_dec_inc;
  logic [1:0]              w_inc;
  logic                    w_commit;
  logic                    w_has1;
  logic                    w_cap;
  logic [5:0]              w_cap_off;
  logic [5:0]              w_off0;
  logic [31:0]             w_d0;
  logic [31:0]             w_d1;
  logic [1:0]              w_we;
  logic [6:0]              w_woff [2];
  logic [31:0]             w_wdat [2];
  logic [NUM_PAGES*64-1:0] w_addr_nxt;
  logic [NUM_PAGES*32-1:0] w_qwords_nxt;
  logic [NUM_PAGES-1:0]    w_unlock_nxt;
  logic [63:0]             w_cbuf_nxt;
  logic                    w_intr_nxt;
  logic [16:0]             w_drop_sum;
  logic                    w_unused;

  assign w_beat   = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
  assign w_sof    = w_beat & ~trn_rsof_n;
  assign w_eof    = w_beat & ~trn_reof_n;
  assign w_dsc    = w_beat & ~trn_rsrc_dsc_n;
  assign w_hit    = ~trn_rbar_hit_n[BAR_INDEX];
  assign w_ft_wr  = (trn_rd[62:56] == FT_WR32) || (trn_rd[62:56] == FT_WR64);
  assign w_len_ok = (trn_rd[41:32] == 10'd1) || (trn_rd[41:32] == 10'd2);
  assign w_unused = ^{trn_rrem_n, trn_rbar_hit_n};

  // Header decode of an SOF beat; shared by S_IDLE and by a fresh SOF cutting into a TLP.
  always_comb begin
    w_dec_state = S_IDLE;
    w_dec_inc   = 1'b0;
    w_dec_load  = 1'b0;
    if (w_sof && w_hit && w_ft_wr) begin
      w_dec_load = 1'b1;
      if (w_dsc || w_eof) begin
        w_dec_inc = 1'b1;
      end else if (!w_len_ok) begin
        w_dec_state = S_DROP;
      end else if (trn_rd[62:56] == FT_WR64) begin
        w_dec_state = S_A4;
      end else begin
        w_dec_state = S_A3;
      end
    end else begin
      w_dec_load = 1'b0;
    end
  end

  // Next state, capture of offset/data0, commit request and drop increment.
  always_comb begin
    w_state_nxt = r_state;
    w_inc       = 2'd0;
    w_commit    = 1'b0;
    w_has1      = 1'b0;
    w_cap       = 1'b0;
    w_cap_off   = r_off;
    w_off0      = r_off;
    w_d0        = r_data0;
    w_d1        = 32'd0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = w_dec_state;
        w_inc       = {1'b0, w_dec_inc};
      end
      S_A3: begin
        if (!w_beat) begin
          w_state_nxt = r_state;
        end else if (w_sof) begin
          w_state_nxt = w_dec_state;
          w_inc       = 2'd1 + {1'b0, w_dec_inc};
        end else if (w_dsc) begin
          w_state_nxt = S_IDLE;
          w_inc       = 2'd1;
        end else if (!r_len2) begin
          if (w_eof) begin
            w_commit    = 1'b1;
            w_off0      = trn_rd[39:34];
            w_d0        = trn_rd[31:0];
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DROP;
          end
        end else if (w_eof) begin
          w_state_nxt = S_IDLE;
          w_inc       = 2'd1;
        end else begin
          w_cap       = 1'b1;
          w_cap_off   = trn_rd[39:34];
          w_state_nxt = S_D;
        end
      end
      S_A4: begin
        if (!w_beat) begin
          w_state_nxt = r_state;
        end else if (w_sof) begin
          w_state_nxt = w_dec_state;
          w_inc       = 2'd1 + {1'b0, w_dec_inc};
        end else if (w_dsc || w_eof) begin
          w_state_nxt = S_IDLE;
          w_inc       = 2'd1;
        end else begin
          w_cap       = 1'b1;
          w_cap_off   = trn_rd[7:2];
          w_state_nxt = S_D;
        end
      end
      S_D: begin
        if (!w_beat) begin
          w_state_nxt = r_state;
        end else if (w_sof) begin
          w_state_nxt = w_dec_state;
          w_inc       = 2'd1 + {1'b0, w_dec_inc};
        end else if (w_dsc) begin
          w_state_nxt = S_IDLE;
          w_inc       = 2'd1;
        end else if (w_eof) begin
          w_commit    = 1'b1;
          w_has1      = r_len2;
          w_state_nxt = S_IDLE;
          if (r_is64) begin
            w_d0 = trn_rd[63:32];
            w_d1 = trn_rd[31:0];
          end else begin
            w_d0 = r_data0;
            w_d1 = trn_rd[63:32];
          end
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (!w_beat) begin
          w_state_nxt = r_state;
        end else if (w_sof) begin
          w_state_nxt = w_dec_state;
          w_inc       = 2'd1 + {1'b0, w_dec_inc};
        end else if (w_dsc || w_eof) begin
          w_state_nxt = S_IDLE;
          w_inc       = 2'd1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Two write ports: data0 to offset, data1 to offset+1 (7-bit so 0x3F+1 maps nowhere).
  assign w_we      = {w_commit & w_has1, w_commit};
  assign w_woff[0] = {1'b0, w_off0};
  assign w_woff[1] = {1'b0, w_off0} + 7'd1;
  assign w_wdat[0] = f_bswap(w_d0);
  assign w_wdat[1] = f_bswap(w_d1);

  // Register-map decode for both write ports.
  always_comb begin
    w_addr_nxt   = r_addr;
    w_qwords_nxt = r_qwords;
    w_unlock_nxt = '0;
    w_cbuf_nxt   = r_cbuf;
    w_intr_nxt   = r_intr;
    for (int p = 0; p < 2; p++) begin
      if (w_we[p]) begin
        for (int i = 0; i < NUM_PAGES; i++) begin
          if (w_woff[p] == 7'(2 * i)) begin
            w_addr_nxt[64*i +: 32] = w_wdat[p];
          end else if (w_woff[p] == 7'(2 * i + 1)) begin
            w_addr_nxt[64*i+32 +: 32] = w_wdat[p];
          end else if (w_woff[p] == 7'(32 + i)) begin
            w_qwords_nxt[32*i +: 32] = w_wdat[p];
            w_unlock_nxt[i]          = 1'b1;
          end else begin
            w_unlock_nxt[i] = w_unlock_nxt[i];
          end
        end
        case (w_woff[p])
          7'h30:   w_cbuf_nxt[31:0]  = w_wdat[p];
          7'h31:   w_cbuf_nxt[63:32] = w_wdat[p];
          7'h32:   w_intr_nxt        = w_wdat[p][0];
          default: w_intr_nxt        = w_intr_nxt;
        endcase
      end else begin
        w_intr_nxt = w_intr_nxt;
      end
    end
  end

  assign w_drop_sum = {1'b0, r_drop} + {15'd0, w_inc};

  // State and register file; status set by the unlock pulse wins over a same-cycle free.
  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_is64   <= 1'b0;
      r_len2   <= 1'b0;
      r_off    <= 6'd0;
      r_data0  <= 32'd0;
      r_addr   <= '0;
      r_qwords <= '0;
      r_status <= '0;
      r_unlock <= '0;
      r_cbuf   <= 64'd0;
      r_intr   <= 1'b0;
      r_drop   <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_dec_load) begin
        r_is64 <= (trn_rd[62:56] == FT_WR64);
        r_len2 <= (trn_rd[41:32] == 10'd2);
      end
      if (w_cap) begin
        r_off   <= w_cap_off;
        r_data0 <= trn_rd[31:0];
      end
      r_addr   <= w_addr_nxt;
      r_qwords <= w_qwords_nxt;
      r_unlock <= w_unlock_nxt;
      r_status <= (r_status & ~huge_page_free) | r_unlock;
      r_cbuf   <= w_cbuf_nxt;
      r_intr   <= w_intr_nxt;
      r_drop   <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign huge_page_addr           = r_addr;
  assign huge_page_qwords         = r_qwords;
  assign huge_page_status         = r_status;
  assign huge_page_unlock         = r_unlock;
  assign completed_buffer_address = r_cbuf;
  assign interrupts_enabled       = r_intr;
  assign dropped_tlp_count        = r_drop;

endmodule

// File: doc/tx_huge_pages_ctrl.md
Name: tx_huge_pages_ctrl

Overview:
- Parametrised successor to the two-page TX huge-page address decoder; sits on the TRN RX stream beside the PIO engine.
- Snoops host memory-write TLPs to a configurable BAR and maintains per-page DMA address, qword count and lock status for NUM_PAGES huge pages.
- Also holds the completion buffer address and an interrupt-enable bit.
- New over the previous generation: 3DW and 4DW writes, 1- or 2-DW payloads, commit-on-EOF with discontinue abort, full reset of all registers, and a drop counter.

Parameters:
- NUM_PAGES, 4, number of huge pages; power of 2, range 1..16.
- BAR_INDEX, 2, trn_rbar_hit_n bit that selects this block.

Ports:
- trn_clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- trn_rd  in  64  RX data; DW0 in [63:32].
- trn_rrem_n  in  8  RX remainder; not used for decode.
- trn_rsof_n  in  1  start of frame, active low.
- trn_reof_n  in  1  end of frame, active low.
- trn_rsrc_rdy_n  in  1  source ready, active low.
- trn_rsrc_dsc_n  in  1  source discontinue, active low.
- trn_rbar_hit_n  in  7  BAR hit, active low.
- trn_rdst_rdy_n  in  1  destination ready, driven by the PIO engine; observed only.
- huge_page_addr  out  NUM_PAGES*64  page i address at [64i+63:64i].
- huge_page_qwords  out  NUM_PAGES*32  page i qword count.
- huge_page_status  out  NUM_PAGES  1 = page filled by host, owned by the TX engine.
- huge_page_unlock  out  NUM_PAGES  one-cycle pulse per qword-count write.
- huge_page_free  in  NUM_PAGES  TX engine releases page i.
- completed_buffer_address  out  64  host completion buffer address.
- interrupts_enabled  out  1  interrupt-enable bit.
- dropped_tlp_count  out  16  saturating count of rejected targeted writes.

Behaviour:
- Beat accepted when trn_rsrc_rdy_n=0 and trn_rdst_rdy_n=0. No other beat is seen.
- Reset: every output and register clears to 0; state goes to S_IDLE. Reset mid-TLP discards the TLP; the rest of that TLP is ignored because only SOF beats are decoded in S_IDLE.
- Register map, DW offset = request address [7:2]:
  - 2i: page i address [31:0].
  - 2i+1: page i address [63:32].
  - 0x20+i: page i qwords.
  - 0x30: completion buffer address low.
  - 0x31: completion buffer address high.
  - 0x32: bit 0 = interrupts_enabled.
  - All other offsets, including pages >= NUM_PAGES: writes are accepted and discarded silently, not counted.
- Data byte order: register [7:0] = payload DW [31:24], [15:8] = [23:16], [23:16] = [15:8], [31:24] = [7:0].
- State machine:
  - S_IDLE: on an accepted SOF beat with rbar_hit_n[BAR_INDEX]=0:
    - fmt/type [62:56] = 7'b10_00000 (WR32) -> S_A3.
    - fmt/type = 7'b11_00000 (WR64) -> S_A4.
    - Any other type is ignored.
    - Latch length [41:32]. Length other than 1 or 2 -> S_DROP.
  - S_A3 (beat 1): offset from [39:34]; data0 = [31:0].
    - length 1 and EOF -> commit.
    - length 2 -> S_D.
  - S_A4 (beat 1): offset from [7:2] -> S_D.
  - S_D: WR64 data0 = [63:32], data1 = [31:0]. WR32 length 2: data1 = [63:32]. Requires EOF; commit.
  - S_DROP: wait for EOF beat -> S_IDLE; increment the counter once.
- Commit happens on the clock edge that accepts the EOF beat, provided trn_rsrc_dsc_n=1 on that beat:
  - data0 is written to offset; data1, if present, to offset+1.
  - Registers are visible the following cycle.
  - Next state is S_IDLE.
- Malformed TLPs: EOF arriving early or late relative to length, or SOF seen outside S_IDLE -> no commit, counter +1. A fresh SOF is then re-decoded as a new TLP.
- Discontinue: trn_rsrc_dsc_n=0 on any accepted beat aborts the TLP with no writes and counter +1; next state is S_IDLE.
- Qwords write to page i:
  - huge_page_unlock[i] pulses in the commit cycle.
  - huge_page_status[i] sets the next edge.
  - huge_page_free[i] clears status. If unlock and free are simultaneous, set wins.
- A 2-DW write spanning 0x2i+1 / 0x2(i+1) is legal; each DW goes to its own register.
- dropped_tlp_count saturates at 16'hFFFF.

Test Plan:
- WR32 length 1 to offset 0x04 (page 2 low), data 0x78563412 -> huge_page_addr[159:128] = 0x12345678 on the cycle after EOF; nothing else changes.
- WR64 length 2 to offset 0x02, data 0x44332211, 0x88776655 -> page 1 address = 0x5566778811223344.
- WR32 to offset 0x21 with data 0x00010000 -> huge_page_unlock[1] pulses for one cycle, huge_page_qwords page 1 = 0x100, status[1] = 1. Assert huge_page_free[1] on the same cycle as a second unlock -> status stays 1. Then free alone -> status = 0.
- WR32 length 2 with trn_rsrc_dsc_n=0 on the final beat -> no register change, dropped_tlp_count = 1. A length-3 write -> count = 2. A write with rbar_hit_n[BAR_INDEX]=1 -> count stays 2.
- Deassert trn_rdst_rdy_n stalls across every state -> results identical to the unstalled run.
- Assert reset between beat 0 and beat 1 of a WR64 -> all outputs 0 and no commit; the next valid TLP is decoded correctly.
